serial_load_ctrl: RTL and testbench

//  Sequencer for the WIDTH-bit serial-in shift register. Accepts a parallel word

---
 rtl/serial_load_ctrl_pkg.sv | 16 +
 rtl/shift_reg_en.sv | 21 ++
 rtl/serial_load_ctrl.sv | 109 ++++++++++
 tb/tb_serial_load_ctrl.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/serial_load_ctrl_pkg.sv
// Shared state encoding and sizing helper for the serial load sequencer.
`timescale 1ns/1ps
package serial_load_ctrl_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_SHIFT = 2'b01,
        S_DONE  = 2'b10
    } state_t;

    // Bits needed to count n distinct values; a counter is never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/shift_reg_en.sv
// WIDTH-bit serial-in shift register; shifts SI in at the LSB on enabled edges.
`timescale 1ns/1ps
module shift_reg_en #(
    parameter int WIDTH = 6
) (
    input  logic             Clock,
    input  logic             Resetn,
    input  logic             en,
    input  logic             SI,
    output logic [WIDTH-1:0] Q
);

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            Q <= '0;
        end else if (en) begin
            Q <= {Q[WIDTH-2:0], SI};
        end
    end

endmodule

// File: rtl/serial_load_ctrl.sv
// Sequencer that loads a parallel word into the serial-in shift register one bit per slot.
`timescale 1ns/1ps
module serial_load_ctrl
    import serial_load_ctrl_pkg::*;
#(
    parameter int WIDTH     = 6,
    parameter bit MSB_FIRST = 1'b1,
    parameter int SHIFT_DIV = 1
) (
    input  logic             Clock,
    input  logic             Resetn,
    input  logic             start,
    input  logic [WIDTH-1:0] din,
    output logic             ready,
    output logic             busy,
    output logic             SI,
    output logic             shift_en,
    output logic             done,
    output logic [WIDTH-1:0] Q
);

    localparam int BCW = cnt_width(WIDTH);
    localparam int DCW = cnt_width(SHIFT_DIV);
    localparam logic [BCW-1:0] BIT_LAST = BCW'(WIDTH - 1);
    localparam logic [DCW-1:0] DIV_LAST = DCW'(SHIFT_DIV - 1);

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] hold;
    logic [BCW-1:0]   bitcnt;
    logic [DCW-1:0]   divcnt;
    logic             accept;

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        ready     = 1'b0;
        SI        = 1'b0;
        shift_en  = 1'b0;
        done      = 1'b0;
        accept    = 1'b0;
        case (state)
            S_IDLE: begin
                ready = 1'b1;
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = S_SHIFT;
                end
            end
            S_SHIFT: begin
                SI       = MSB_FIRST ? hold[WIDTH-1] : hold[0];
                shift_en = (divcnt == DIV_LAST);
                if (shift_en && (bitcnt == BIT_LAST)) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    assign busy = ~ready;

    // bitcnt parks at its terminal value on the last shift instead of wrapping.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            hold   <= '0;
            bitcnt <= '0;
            divcnt <= '0;
        end else if (accept) begin
            hold   <= din;
            bitcnt <= '0;
            divcnt <= '0;
        end else if (state == S_SHIFT) begin
            if (shift_en) begin
                hold   <= MSB_FIRST ? (hold << 1) : (hold >> 1);
                divcnt <= '0;
                if (bitcnt != BIT_LAST) begin
                    bitcnt <= bitcnt + 1'b1;
                end
            end else begin
                divcnt <= divcnt + 1'b1;
            end
        end
    end

    shift_reg_en #(
        .WIDTH(WIDTH)
    ) u_sreg (
        .Clock (Clock),
        .Resetn(Resetn),
        .en    (shift_en),
        .SI    (SI),
        .Q     (Q)
    );

endmodule

// File: tb/tb_serial_load_ctrl.sv
// Bench for serial_load_ctrl: three configurations (MSB-first, slow slots, LSB-first) against a slot-timing model.
`timescale 1ns/1ps
module tb_serial_load_ctrl;

    localparam int W    = 6;
    localparam int NDUT = 3;

    logic            clk;
    logic            rst_n;
    logic [NDUT-1:0] start_v;
    logic [W-1:0]    din_v [NDUT];
    logic [NDUT-1:0] ready_v;
    logic [NDUT-1:0] busy_v;
    logic [NDUT-1:0] si_v;
    logic [NDUT-1:0] shift_en_v;
    logic [NDUT-1:0] done_v;
    logic [W-1:0]    q_v [NDUT];
    logic [W-1:0]    q_model [NDUT];
    int              checks = 0;
    int              errors = 0;

    typedef struct {
        int           d;
        logic [W-1:0] din;
        int           noise;
        bit           hold;
        logic [W-1:0] q_exp;
    } vec_t;

    vec_t vecs [8];

    serial_load_ctrl #(.WIDTH(W), .MSB_FIRST(1'b1), .SHIFT_DIV(1)) u_msb (
        .Clock(clk), .Resetn(rst_n), .start(start_v[0]), .din(din_v[0]),
        .ready(ready_v[0]), .busy(busy_v[0]), .SI(si_v[0]), .shift_en(shift_en_v[0]),
        .done(done_v[0]), .Q(q_v[0])
    );

    serial_load_ctrl #(.WIDTH(W), .MSB_FIRST(1'b1), .SHIFT_DIV(3)) u_div (
        .Clock(clk), .Resetn(rst_n), .start(start_v[1]), .din(din_v[1]),
        .ready(ready_v[1]), .busy(busy_v[1]), .SI(si_v[1]), .shift_en(shift_en_v[1]),
        .done(done_v[1]), .Q(q_v[1])
    );

    serial_load_ctrl #(.WIDTH(W), .MSB_FIRST(1'b0), .SHIFT_DIV(1)) u_lsb (
        .Clock(clk), .Resetn(rst_n), .start(start_v[2]), .din(din_v[2]),
        .ready(ready_v[2]), .busy(busy_v[2]), .SI(si_v[2]), .shift_en(shift_en_v[2]),
        .done(done_v[2]), .Q(q_v[2])
    );

    initial clk = 1'b0;
    always #20 clk = ~clk;

    initial begin
        #5000000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic int div_of(input int d);
        return (d == 1) ? 3 : 1;
    endfunction

    function automatic bit msb_of(input int d);
        return d != 2;
    endfunction

    // Serial bit sent in slot s.
    function automatic logic bit_at(input int d, input logic [W-1:0] w, input int s);
        return msb_of(d) ? w[W-1-s] : w[s];
    endfunction

    // Register contents after the first n slots of word w have been shifted in on top of prev.
    function automatic logic [W-1:0] after_shifts(input int d, input logic [W-1:0] prev,
                                                  input logic [W-1:0] w, input int n);
        logic [W-1:0] q;
        q = prev;
        for (int i = 0; i < n; i++) begin
            q = W'((q << 1) | W'(bit_at(d, w, i)));
        end
        return q;
    endfunction

    function automatic logic [W-1:0] reverse_word(input logic [W-1:0] w);
        logic [W-1:0] r;
        for (int i = 0; i < W; i++) begin
            r[i] = w[W-1-i];
        end
        return r;
    endfunction

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_idle(input int d, input string tag);
        check_output($sformatf("dut%0d.%s.ready", d, tag), ready_v[d], 1);
        check_output($sformatf("dut%0d.%s.busy", d, tag), busy_v[d], 0);
        check_output($sformatf("dut%0d.%s.si", d, tag), si_v[d], 0);
        check_output($sformatf("dut%0d.%s.shift_en", d, tag), shift_en_v[d], 0);
        check_output($sformatf("dut%0d.%s.done", d, tag), done_v[d], 0);
        check_output($sformatf("dut%0d.%s.q", d, tag), q_v[d], q_model[d]);
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            for (int d = 0; d < NDUT; d++) begin
                check_idle(d, "idle");
                din_v[d] = W'($urandom);
            end
        end
    endtask

    // Entered and left at a negedge with the DUT idle. noise: 0 none, 1 random start/din while
    // busy, 2 an all-ones start pulse landing on edge 3.
    task automatic apply_stimulus(input int d, input logic [W-1:0] word, input int noise,
                                  input bit hold_start);
        int           div;
        int           last;
        int           n;
        logic [W-1:0] prev;
        div  = div_of(d);
        last = W * div;
        prev = q_model[d];
        check_output($sformatf("dut%0d.ready_before_start", d), ready_v[d], 1);
        start_v[d] = 1'b1;
        din_v[d]   = word;
        @(posedge clk);
        #1;
        start_v[d] = hold_start;
        for (int k = 0; k <= last; k++) begin
            @(negedge clk);
            n = (k / div < W) ? k / div : W;
            check_output($sformatf("dut%0d.k%0d.ready", d, k), ready_v[d], 0);
            check_output($sformatf("dut%0d.k%0d.busy", d, k), busy_v[d], 1);
            check_output($sformatf("dut%0d.k%0d.done", d, k), done_v[d], (k == last));
            check_output($sformatf("dut%0d.k%0d.shift_en", d, k), shift_en_v[d],
                         (k < last) && (k % div == div - 1));
            check_output($sformatf("dut%0d.k%0d.si", d, k), si_v[d],
                         (k < last) ? bit_at(d, word, k / div) : 1'b0);
            check_output($sformatf("dut%0d.k%0d.q", d, k), q_v[d], after_shifts(d, prev, word, n));
            if (noise == 1) begin
                start_v[d] = hold_start | 1'($urandom_range(0, 1));
                din_v[d]   = W'($urandom);
            end else if (noise == 2 && k == 2) begin
                start_v[d] = 1'b1;
                din_v[d]   = '1;
            end else if (noise == 2 && k == 3) begin
                start_v[d] = hold_start;
                din_v[d]   = word;
            end
        end
        @(negedge clk);
        q_model[d] = after_shifts(d, prev, word, W);
        check_idle(d, "after_transfer");
        start_v[d] = hold_start;
    endtask

    initial begin
        int           rd;
        logic [W-1:0] rw;

        vecs[0] = '{0, 6'b101101, 0, 1'b0, 6'b101101};
        vecs[1] = '{0, 6'b101101, 2, 1'b0, 6'b101101};
        vecs[2] = '{1, 6'b010011, 0, 1'b0, 6'b010011};
        vecs[3] = '{2, 6'b110000, 0, 1'b0, 6'b000011};
        vecs[4] = '{0, 6'b000001, 0, 1'b1, 6'b000001};
        vecs[5] = '{0, 6'b100000, 0, 1'b0, 6'b100000};
        vecs[6] = '{2, 6'b101100, 1, 1'b0, 6'b001101};
        vecs[7] = '{1, 6'b111000, 1, 1'b0, 6'b111000};

        rst_n   = 1'b0;
        start_v = '0;
        for (int d = 0; d < NDUT; d++) begin
            din_v[d]   = '0;
            q_model[d] = '0;
        end

        @(negedge clk);
        for (int d = 0; d < NDUT; d++) check_idle(d, "reset");
        rst_n = 1'b1;
        idle_cycles(2);

        for (int i = 0; i < 8; i++) begin
            apply_stimulus(vecs[i].d, vecs[i].din, vecs[i].noise, vecs[i].hold);
            check_output($sformatf("vec%0d.final_q", i), q_v[vecs[i].d], vecs[i].q_exp);
        end
        idle_cycles(1);

        // Asynchronous reset in the middle of a clock phase, three shifts into a transfer.
        start_v[0] = 1'b1;
        din_v[0]   = 6'b101101;
        @(posedge clk);
        #1;
        start_v[0] = 1'b0;
        repeat (3) @(posedge clk);
        #10;
        check_output("abort.q_before_reset", q_v[0], after_shifts(0, q_model[0], 6'b101101, 3));
        rst_n = 1'b0;
        #1;
        check_output("abort.q", q_v[0], 0);
        check_output("abort.si", si_v[0], 0);
        check_output("abort.ready", ready_v[0], 1);
        check_output("abort.busy", busy_v[0], 0);
        check_output("abort.shift_en", shift_en_v[0], 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int d = 0; d < NDUT; d++) q_model[d] = '0;
        idle_cycles(4);

        for (int t = 0; t < 24; t++) begin
            rd = $urandom_range(0, NDUT - 1);
            rw = W'($urandom);
            apply_stimulus(rd, rw, int'($urandom_range(0, 1)), 1'b0);
            check_output($sformatf("rand%0d.final_q", t), q_v[rd], msb_of(rd) ? rw : reverse_word(rw));
            idle_cycles($urandom_range(0, 2));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
